// File: rtl/serial_pattern_tx_if.sv
// Load-side handshake bundle for serial_pattern_tx: a parallel pattern offered
// over valid/ready together with its bit length and extra-repeat count.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;

  // Producer side: offers patterns, watches ready.
  modport master (
    output load_valid, load_data, load_len, load_rep,
    input  load_ready
  );

  // Transmitter side: consumes patterns, drives ready.
  modport slave (
    input  load_valid, load_data, load_len, load_rep,
    output load_ready
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter. Latches a pattern on a valid/ready accept,
// shifts it out MSB-first (bit len-1 first), one bit per clock, and repeats it
// load_rep extra times with GAP_CYCLES zero-filled idle cycles between copies.
// A single-cycle done pulse follows the last bit of the last copy.
module serial_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_pattern_tx_if.slave    load,
  output logic                  out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);
  localparam logic [IDX_W-1:0] WIDTH_M1  = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [IDX_W-1:0] len_m1_q, len_m1_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [REP_W-1:0] reps_q, reps_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             out_n;
  logic [IDX_W-1:0] load_len_m1;

  // Length 0 or anything beyond WIDTH means a full-width pattern.
  always_comb begin
    if (load.load_len == '0 || load.load_len > WIDTH_LEN) begin
      load_len_m1 = WIDTH_M1;
    end else begin
      load_len_m1 = IDX_W'(load.load_len - 1'b1);
    end
  end

  // Next-state and next-register logic for the transmit sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which is what keeps this block from inferring latches.
    state_n  = state_q;
    data_n   = data_q;
    len_m1_n = len_m1_q;
    idx_n    = idx_q;
    reps_n   = reps_q;
    gap_n    = gap_q;

    unique case (state_q)
      IDLE: begin
        if (load.load_valid) begin
          data_n   = load.load_data;
          len_m1_n = load_len_m1;
          idx_n    = load_len_m1;
          reps_n   = load.load_rep;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_n = idx_q - 1'b1;
        end else if (reps_q != '0) begin
          reps_n = reps_q - 1'b1;
          idx_n  = len_m1_q;
          if (GAP_CYCLES == 0) begin
            state_n = SHIFT;
          end else begin
            state_n = GAP;
            gap_n   = GAP_LOAD;
          end
        end else begin
          state_n = DONE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_n = SHIFT;
        end else begin
          gap_n = gap_q - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // The serial bit is registered, so it is chosen from the values the
    // sequencer will hold next cycle; outside SHIFT the line idles at 0.
    out_n = (state_n == SHIFT) ? data_n[idx_n] : 1'b0;
  end

  // State and datapath registers; reset clears everything, including the
  // latched pattern, so no stale bits survive an aborted transfer.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_m1_q  <= '0;
      idx_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      len_m1_q  <= len_m1_n;
      idx_q     <= idx_n;
      reps_q    <= reps_n;
      gap_q     <= gap_n;
      out       <= out_n;
      out_valid <= (state_n == SHIFT);
    end
  end

  // Status outputs decode straight from the state register, so they follow an
  // asynchronous reset in the same cycle.
  assign load.load_ready = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (WIDTH=8, REP_W=4, GAP_CYCLES=2).
// Each cycle's outputs are packed as {out, out_valid, busy, done, load_ready}.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int GAP   = 2;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic clock;
  logic reset;
  logic out, out_valid, busy, done;

  int vectors    = 0;
  int miscompares = 0;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .REP_W(REP_W), .LEN_W(LEN_W)) bus ();

  serial_pattern_tx #(
    .WIDTH(WIDTH), .REP_W(REP_W), .GAP_CYCLES(GAP), .LEN_W(LEN_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (bus.slave),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent 111 detector (overlapping) watching the serial line.
  logic       det_clear = 1'b1;
  logic [2:0] det_hist;
  int         det_hits;
  always @(posedge clock) begin
    if (det_clear) begin
      det_hist <= 3'b000;
      det_hits <= 0;
    end else begin
      det_hist <= {det_hist[1:0], out & out_valid};
      if ({det_hist[1:0], out & out_valid} == 3'b111) det_hits <= det_hits + 1;
    end
  end

  // Watchdog: the sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {out, out_valid, busy, done, bus.load_ready};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one job, then check every output cycle against hand-written
  // out / out_valid sequences (n bits, first cycle in bit n-1), the done cycle
  // and the following idle cycle. load_data is scrambled while busy.
  task automatic run_job(input string tag, input logic [7:0] d, input logic [3:0] len,
                         input logic [3:0] rep, input int n,
                         input logic [31:0] eo, input logic [31:0] ev);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_len   = len;
    bus.load_rep   = rep;
    step();
    bus.load_valid = 1'b0;
    bus.load_data  = ~d;
    bus.load_len   = 4'd1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i + 1), 32'(outs()),
            32'({eo[n-1-i], ev[n-1-i], 1'b1, 1'b0, 1'b0}));
      step();
    end
    check($sformatf("%s_done", tag), 32'(outs()), 32'(5'b00110));
    step();
    check($sformatf("%s_idle", tag), 32'(outs()), 32'(5'b00001));
  endtask

  initial begin
    int busy_cnt, valid_cnt, ones_cnt;
    logic seen_done;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    bus.load_rep   = '0;
    reset = 1'b0;

    // 1: reset held low for two cycles.
    step();
    step();
    check("reset_state", 32'(outs()), 32'(5'b00001));
    reset = 1'b1;
    step();
    check("post_reset_idle", 32'(outs()), 32'(5'b00001));

    // 2: 3'b111, single copy; the 111 detector must fire exactly once.
    det_clear = 1'b0;
    run_job("j07", 8'h07, 4'd3, 4'd0, 3, 32'b111, 32'b111);
    step();
    check("det_111_hits", 32'(det_hits), 32'd1);
    det_clear = 1'b1;

    // 3: len=0 means full width.
    run_job("jA5", 8'hA5, 4'd0, 4'd0, 8, 32'b10100101, 32'b11111111);

    // 4: two-bit pattern, two extra copies with two-cycle gaps.
    run_job("jrep", 8'b10, 4'd2, 4'd2, 10, 32'b1000100010, 32'b1100110011);

    // len above WIDTH is also full width.
    run_job("jlen12", 8'h3C, 4'd12, 4'd0, 8, 32'b00111100, 32'b11111111);

    // len=1 with high bits set: only bit 0 may ever appear.
    run_job("jlen1", 8'hFE, 4'd1, 4'd1, 4, 32'b0000, 32'b1001);

    // Max repeat count: 16 copies of one bit, 16 + 15*2 + 1 = 47 busy cycles.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFD;
    bus.load_len   = 4'd1;
    bus.load_rep   = 4'd15;
    step();
    bus.load_valid = 1'b0;
    busy_cnt = 0; valid_cnt = 0; ones_cnt = 0; seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (out) ones_cnt++;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      step();
    end
    check("repmax_done_seen", 32'(seen_done), 32'd1);
    check("repmax_busy_cycles", 32'(busy_cnt), 32'd47);
    check("repmax_bits", 32'(valid_cnt), 32'd16);
    check("repmax_ones", 32'(ones_cnt), 32'd16);
    step();
    check("repmax_idle", 32'(outs()), 32'(5'b00001));

    // 5: reset pulsed during bit 3 of an 8-bit send.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    bus.load_len   = 4'd8;
    bus.load_rep   = 4'd0;
    step();
    bus.load_valid = 1'b0;
    check("abort_bit1", 32'(outs()), 32'(5'b11100));
    step();
    step();
    check("abort_bit3", 32'(outs()), 32'(5'b11100));
    reset = 1'b0;
    #1;
    check("abort_async", 32'(outs()), 32'(5'b00001));
    step();
    check("abort_held", 32'(outs()), 32'(5'b00001));
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("abort_nodone_%0d", i), 32'(outs()), 32'(5'b00001));
    end
    run_job("after_abort", 8'h05, 4'd3, 4'd0, 3, 32'b101, 32'b111);

    // 6: load_valid held high across two back-to-back jobs.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h03;
    bus.load_len   = 4'd2;
    bus.load_rep   = 4'd0;
    step();
    check("b2b_a_c1", 32'(outs()), 32'(5'b11100));
    bus.load_data  = 8'h02;
    step();
    check("b2b_a_c2", 32'(outs()), 32'(5'b11100));
    step();
    check("b2b_a_done", 32'(outs()), 32'(5'b00110));
    step();
    check("b2b_gap_idle", 32'(outs()), 32'(5'b00001));
    step();
    bus.load_valid = 1'b0;
    check("b2b_b_c1", 32'(outs()), 32'(5'b11100));
    step();
    check("b2b_b_c2", 32'(outs()), 32'(5'b01100));
    step();
    check("b2b_b_done", 32'(outs()), 32'(5'b00110));
    step();
    check("b2b_b_idle", 32'(outs()), 32'(5'b00001));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
